// File: rtl/mips_pkg.sv
// Shared types for the MIPS hazard controller: scoreboard entry layout,
// forwarding encoding and the register-match helper.
package mips_pkg;

  // Entries hold register indices at this width; narrower REG_AW values zero-extend.
  localparam int SB_AW = 8;

  localparam int FWD_NONE = 0;
  localparam logic [SB_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] rd;
    logic             regwrite;
    logic             memread;
    logic [SB_AW-1:0] rs;
    logic [SB_AW-1:0] rt;
  } sb_entry_t;

  function automatic logic sb_match(input sb_entry_t e, input logic [SB_AW-1:0] r);
    return e.valid && e.regwrite && (e.rd == r) && (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/mips_sb_stage.sv
// One scoreboard slot: captures its input when load is high, otherwise
// collapses to an all-zero bubble.
module mips_sb_stage
  import mips_pkg::*;
(
  input  logic      CLK,
  input  logic      RST_N,
  input  logic      load,
  input  sb_entry_t d,
  output sb_entry_t q
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) q <= '0;
    else        q <= load ? d : '0;
  end

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Interlock, bypass-select and redirect-flush control for the ID/EX/MEM/WB
// pipeline, driven from a shadow scoreboard of in-flight destinations.
module mips_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_is_md,
  input  logic              md_busy,
  input  logic              redirect,
  output logic              stall,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              md_start,
  output logic [SEL_W-1:0]  fwd_a_sel,
  output logic [SEL_W-1:0]  fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  sb_entry_t        sb_q [1:DEPTH];
  sb_entry_t        id_entry;
  logic [SB_AW-1:0] rs_x, rt_x;
  logic             load_use, md_hold, issue;

  assign rs_x = SB_AW'(id_rs);
  assign rt_x = SB_AW'(id_rt);

  assign id_entry = '{valid: 1'b1, rd: SB_AW'(id_rd), regwrite: id_regwrite,
                      memread: id_memread, rs: rs_x, rt: rt_x};

  assign load_use = id_valid & sb_q[1].memread &
                    ((id_rs_used & sb_match(sb_q[1], rs_x)) |
                     (id_rt_used & sb_match(sb_q[1], rt_x)));
  assign md_hold  = id_valid & id_is_md & md_busy;

  // Outputs are forced low during reset even if the ID inputs still demand a stall.
  assign stall      = RST_N & (load_use | md_hold) & ~redirect;
  assign flush_ifid = RST_N & redirect;
  assign flush_idex = RST_N & redirect;
  assign issue      = id_valid & ~stall & ~redirect;
  assign md_start   = RST_N & issue & id_is_md & ~md_busy;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_sb
    if (k == 1) begin : g_head
      mips_sb_stage u_stage (
        .CLK  (CLK),
        .RST_N(RST_N),
        .load (issue),
        .d    (id_entry),
        .q    (sb_q[1])
      );
    end else begin : g_tail
      mips_sb_stage u_stage (
        .CLK  (CLK),
        .RST_N(RST_N),
        .load (1'b1),
        .d    (sb_q[k-1]),
        .q    (sb_q[k])
      );
    end
  end

  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    fwd_a_sel = SEL_W'(FWD_NONE);
    fwd_b_sel = SEL_W'(FWD_NONE);
    for (int k = DEPTH; k >= 2; k--) begin
      if (sb_q[1].valid && sb_match(sb_q[k], sb_q[1].rs)) fwd_a_sel = SEL_W'(k - 1);
      if (sb_q[1].valid && sb_match(sb_q[k], sb_q[1].rt)) fwd_b_sel = SEL_W'(k - 1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))    stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Directed bench for mips_hazard_ctrl: load-use, forwarding priority, $0,
// mul/div interlock, redirect, mid-stall reset and counter saturation.
module tb_mips_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        id_valid, id_rs_used, id_rt_used, id_regwrite, id_memread, id_is_md;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        md_busy, redirect;
  logic        stall, flush_ifid, flush_idex, md_start;
  logic [2:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  mips_hazard_ctrl dut (
    .CLK(CLK), .RST_N(RST_N),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_is_md(id_is_md), .md_busy(md_busy), .redirect(redirect),
    .stall(stall), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .md_start(md_start), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic id_set(input logic [4:0] rs, input logic [4:0] rt,
                        input logic rsu, input logic rtu,
                        input logic [4:0] rd, input logic rw,
                        input logic mr, input logic md);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_rd = rd; id_regwrite = rw; id_memread = mr; id_is_md = md;
  endtask

  task automatic id_none();
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    id_rd = '0; id_regwrite = 1'b0; id_memread = 1'b0; id_is_md = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  initial begin
    id_none();
    md_busy  = 1'b0;
    redirect = 1'b0;
    #2 RST_N = 1'b0;
    #10;
    chk("rst_stall", stall, 0);
    chk("rst_flush_ifid", flush_ifid, 0);
    chk("rst_flush_idex", flush_idex, 0);
    chk("rst_md_start", md_start, 0);
    chk("rst_fwd_a", fwd_a_sel, 0);
    chk("rst_fwd_b", fwd_b_sel, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    // lw $2 ; add $3,$2,$4
    tick(); id_set(5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0); settle();
    chk("lu_lw_no_stall", stall, 0);
    tick(); id_set(5'd2, 5'd4, 1, 1, 5'd3, 1, 0, 0); settle();
    chk("lu_stall", stall, 1);
    chk("lu_no_md_start", md_start, 0);
    tick(); settle();
    chk("lu_stall_one_cycle", stall, 0);
    tick(); id_none(); settle();
    chk("lu_fwd_a", fwd_a_sel, 2);
    chk("lu_fwd_b", fwd_b_sel, 0);
    chk("lu_stall_cnt", stall_cnt, 1);

    // add $2 ; sub $5,$2,$2
    tick(); id_set(5'd7, 5'd8, 1, 1, 5'd2, 1, 0, 0); settle();
    chk("alu_add_no_stall", stall, 0);
    tick(); id_set(5'd2, 5'd2, 1, 1, 5'd5, 1, 0, 0); settle();
    chk("alu_sub_no_stall", stall, 0);
    tick(); id_none(); settle();
    chk("alu_fwd_a", fwd_a_sel, 1);
    chk("alu_fwd_b", fwd_b_sel, 1);

    // add $9 ; add $9 ; or $6,$9,$0 -> youngest producer wins
    tick(); id_set(5'd1, 5'd1, 1, 1, 5'd9, 1, 0, 0);
    tick(); id_set(5'd1, 5'd1, 1, 1, 5'd9, 1, 0, 0);
    tick(); id_set(5'd9, 5'd0, 1, 1, 5'd6, 1, 0, 0); settle();
    chk("prio_no_stall", stall, 0);
    tick(); id_none(); settle();
    chk("prio_fwd_a_youngest", fwd_a_sel, 1);
    chk("prio_fwd_b_zero", fwd_b_sel, 0);

    // lw $0 ; or $6,$0,$1 -> register 0 never hazards
    tick(); id_set(5'd1, 5'd1, 1, 0, 5'd0, 1, 1, 0); settle();
    tick(); id_set(5'd0, 5'd1, 1, 1, 5'd6, 1, 0, 0); settle();
    chk("r0_no_stall", stall, 0);
    tick(); id_none(); settle();
    chk("r0_fwd_a", fwd_a_sel, 0);
    chk("r0_fwd_b", fwd_b_sel, 0);

    // mult with md_busy held for 4 cycles
    tick(); id_set(5'd4, 5'd5, 1, 1, 5'd0, 0, 0, 1); md_busy = 1'b1; settle();
    chk("md_stall_c0", stall, 1);
    chk("md_start_c0", md_start, 0);
    for (int i = 1; i < 4; i++) begin
      tick(); settle();
      chk($sformatf("md_stall_c%0d", i), stall, 1);
      chk($sformatf("md_start_c%0d", i), md_start, 0);
    end
    tick(); md_busy = 1'b0; settle();
    chk("md_release_stall", stall, 0);
    chk("md_start_pulse", md_start, 1);
    tick(); id_none(); settle();
    chk("md_start_single", md_start, 0);
    chk("md_stall_cnt", stall_cnt, 5);

    // lw $3 ; add using $3 while redirect resolves
    tick(); id_set(5'd1, 5'd0, 1, 0, 5'd3, 1, 1, 0); settle();
    tick(); id_set(5'd3, 5'd0, 1, 0, 5'd7, 1, 0, 0); redirect = 1'b1; settle();
    chk("rd_stall_masked", stall, 0);
    chk("rd_flush_ifid", flush_ifid, 1);
    chk("rd_flush_idex", flush_idex, 1);
    tick(); redirect = 1'b0; id_none(); settle();
    chk("rd_flush_clear", flush_ifid, 0);
    chk("rd_s1_bubble_fwd", fwd_a_sel, 0);
    chk("rd_flush_cnt", flush_cnt, 1);
    chk("rd_stall_cnt_kept", stall_cnt, 5);

    // Reset in the middle of a load-use stall
    tick(); id_set(5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0); settle();
    tick(); id_set(5'd2, 5'd0, 1, 0, 5'd4, 1, 0, 0); settle();
    chk("mr_stall_before", stall, 1);
    #1;
    RST_N = 1'b0; redirect = 1'b1; id_is_md = 1'b1; md_busy = 1'b1;
    #1;
    chk("mr_stall", stall, 0);
    chk("mr_flush_ifid", flush_ifid, 0);
    chk("mr_flush_idex", flush_idex, 0);
    chk("mr_md_start", md_start, 0);
    chk("mr_fwd_a", fwd_a_sel, 0);
    chk("mr_stall_cnt", stall_cnt, 0);
    chk("mr_flush_cnt", flush_cnt, 0);
    tick();
    redirect = 1'b0; md_busy = 1'b0;
    RST_N = 1'b1;
    id_set(5'd2, 5'd4, 1, 1, 5'd12, 1, 0, 0); settle();
    chk("mr_first_no_stall", stall, 0);
    tick(); id_none(); settle();
    chk("mr_first_fwd_a", fwd_a_sel, 0);
    chk("mr_first_fwd_b", fwd_b_sel, 0);

    // Continuous mul/div stall drives stall_cnt to saturation
    tick(); id_set(5'd4, 5'd5, 1, 1, 5'd0, 0, 0, 1); md_busy = 1'b1;
    repeat (65534) @(posedge CLK);
    #1;
    chk("sat_below_max", stall_cnt, 16'hFFFE);
    @(posedge CLK);
    #1;
    chk("sat_max", stall_cnt, 16'hFFFF);
    repeat (4) @(posedge CLK);
    #1;
    chk("sat_hold", stall_cnt, 16'hFFFF);
    chk("sat_still_stalling", stall, 1);
    chk("sat_flush_cnt", flush_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_hazard_ctrl.md
Name: mips_hazard_ctrl

Overview:
Parametrised hazard, forwarding and flush controller for the pipelined MIPS core. It adds interlocks, bypass control and redirect flushing, which the first-generation pipeline does not have.
It sits beside the ID/EX/MEM/WB pipeline registers and keeps its own shadow scoreboard of in-flight destination registers. From that scoreboard it drives stall, flush and forwarding selects every cycle, plus a start handshake to a multi-cycle mul/div unit and saturating performance counters.

Parameters:
REG_AW, 5, register index width
DEPTH, 3, scoreboard stages after ID (S1=EX, S2=MEM, S3=WB); legal range 2..7
SEL_W, 3, forwarding-select width; must satisfy 2**SEL_W > DEPTH-1
CNT_W, 16, performance counter width

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
id_valid  in  1  valid instruction in IF/ID
id_rs  in  REG_AW  ID source A
id_rt  in  REG_AW  ID source B
id_rs_used  in  1  ID reads rs
id_rt_used  in  1  ID reads rt
id_rd  in  REG_AW  ID destination, already RegDst-muxed
id_regwrite  in  1  ID writes a register
id_memread  in  1  ID is a load
id_is_md  in  1  ID is a multi-cycle mul/div
md_busy  in  1  mul/div unit busy
redirect  in  1  taken branch or jump resolved in EX this cycle
stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
flush_ifid  out  1  squash IF/ID
flush_idex  out  1  squash ID/EX
md_start  out  1  one-cycle start pulse to mul/div
fwd_a_sel  out  SEL_W  EX operand A source: 0=regfile, k=stage S(k+1)
fwd_b_sel  out  SEL_W  EX operand B source, same encoding
stall_cnt  out  CNT_W  cycles with stall=1
flush_cnt  out  CNT_W  cycles with redirect=1

Behaviour:
- Reset: while RST_N=0 (asynchronous), all scoreboard valid bits, the EX source registers and both counters clear. stall, flush_*, md_start and fwd_*_sel read 0.
- Scoreboard:
  - Per stage k: valid, rd, regwrite, memread, rs, rt. S1 also holds the EX operands.
  - Every cycle S(k+1) <= S(k).
  - S1 <= the ID instruction when issue = id_valid & ~stall & ~redirect; otherwise S1 <= bubble (valid=0).
  - S(DEPTH) retires.
- Hazard match: an entry matches source r iff entry.valid & entry.regwrite & entry.rd == r & r != 0. Register 0 never matches.
- Load-use stall: id_valid and an ID source in use matches S1 with S1.memread. Stall lasts exactly 1 cycle.
- Mul/div stall: id_valid & id_is_md & md_busy.
- stall = (load-use | mul/div) & ~redirect. It is combinational, valid in the same cycle as the ID inputs.
- md_start = issue & id_is_md & ~md_busy. At most one pulse per issued instruction.
- Redirect:
  - flush_ifid = flush_idex = redirect, same cycle.
  - Redirect has priority over stall.
  - The ID instruction is discarded and S1 loads a bubble.
  - Entries already in S2..S(DEPTH) are unaffected.
- Forwarding:
  - For S1.rs (resp. S1.rt), choose the youngest matching stage among S2..S(DEPTH) and output k-1; output 0 if none match.
  - A matching load in S2 forwards from S2. The load-use stall guarantees its data is already in MEM/WB.
- Register file is write-through. An ID read of the register being written by S(DEPTH) needs no forwarding.
- Counters:
  - stall_cnt increments on each stall=1 cycle; flush_cnt on each redirect=1 cycle.
  - Both saturate at all-ones, no wrap.
- Simultaneous: stall and redirect together means redirect only (stall=0). A load-use hazard and md_busy together produce one stall.

Decomposition:
- Package mips_pkg: FWD_NONE=0 encoding, REG_ZERO, scoreboard entry struct (valid, rd, regwrite, memread, rs, rt).
- Sub-module mips_sb_stage: one resettable scoreboard entry with load/bubble input, instantiated DEPTH times.
- Match and priority logic stays in mips_hazard_ctrl.

Test Plan:
- lw $2 then add $3,$2,$4 back-to-back -> stall=1 for exactly 1 cycle; add reaches EX with fwd_a_sel=2 (MEM/WB); stall_cnt=1.
- add $2 then sub $5,$2,$2 -> no stall; fwd_a_sel=1 and fwd_b_sel=1 when sub is in EX.
- add $0,... then or $6,$0,$1 -> fwd_a_sel=0, no stall.
- mult issued with md_busy=1 for 4 cycles -> stall=1 for 4 cycles; md_start pulses once, on the cycle md_busy falls.
- redirect=1 while ID holds a load-use hazard -> stall=0, flush_ifid=flush_idex=1, S1 bubble next cycle, flush_cnt=1.
- RST_N low mid-stall with valid entries -> all outputs 0 immediately. After release, the first independent instruction issues with no stall or forward.
- Preload stall_cnt to 0xFFFF with a continuous stall -> stall_cnt stays at 0xFFFF.
